// File: rtl/mem_sdram_scheduler.sv
// mem_sdram_scheduler
// Shares the single SDRAM mem_bus target among NUM_SOURCES requesters.
// Source 0 (N64) has priority. It is limited to PRIO_MAX_BURST consecutive
// grants while any other source is waiting (0 = unlimited). Sources
// 1..NUM_SOURCES-1 are served round-robin.
//
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   src_request     per-source request, held until that source's ack
//   src_write       per-source write flag
//   src_wmask       packed byte masks, source i at [i*MASK_W +: MASK_W]
//   src_address     packed addresses, source i at [i*ADDR_W +: ADDR_W]
//   src_wdata       packed write data, source i at [i*DATA_W +: DATA_W]
//   src_ack         one-hot ack to the granted source (mem_ack cycle only)
//   src_rdata       read data broadcast (mem_rdata passthrough)
//   mem_request     request to the SDRAM controller
//   mem_write/wmask/address/wdata  fields latched at grant
//   mem_ack         one-cycle completion strobe from the SDRAM controller
//   mem_rdata       read data, valid with mem_ack
//   busy            a transaction is outstanding
//   grant_source    index of the current or last granted source
module mem_sdram_scheduler #(
  parameter int NUM_SOURCES    = 4,
  parameter int ADDR_W         = 27,
  parameter int DATA_W         = 16,
  parameter int MASK_W         = DATA_W / 8,
  parameter int PRIO_MAX_BURST = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_SOURCES-1:0]        src_request,
  input  logic [NUM_SOURCES-1:0]        src_write,
  input  logic [NUM_SOURCES*MASK_W-1:0] src_wmask,
  input  logic [NUM_SOURCES*ADDR_W-1:0] src_address,
  input  logic [NUM_SOURCES*DATA_W-1:0] src_wdata,
  output logic [NUM_SOURCES-1:0]        src_ack,
  output logic [DATA_W-1:0]             src_rdata,
  output logic                          mem_request,
  output logic                          mem_write,
  output logic [MASK_W-1:0]             mem_wmask,
  output logic [ADDR_W-1:0]             mem_address,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic                          mem_ack,
  input  logic [DATA_W-1:0]             mem_rdata,
  output logic                          busy,
  output logic [$clog2(NUM_SOURCES)-1:0] grant_source
);

  localparam int GS_W = $clog2(NUM_SOURCES);
  localparam int PC_W = (PRIO_MAX_BURST > 0) ? $clog2(PRIO_MAX_BURST + 1) : 1;
  localparam logic [PC_W-1:0] PC_MAX   = PC_W'(PRIO_MAX_BURST);
  localparam logic [GS_W-1:0] RR_RESET = GS_W'(NUM_SOURCES - 1);

  typedef enum logic {
    IDLE,
    WAIT
  } state_t;

  state_t              state, state_next;
  logic [GS_W-1:0]     rr_ptr;
  logic [GS_W-1:0]     rr_cand;
  logic [GS_W-1:0]     rr_winner;
  logic [GS_W-1:0]     winner;
  logic [PC_W-1:0]     prio_count;
  logic                rr_found;
  logic                others_pending;
  logic                any_request;
  logic                prio_wins;
  logic                sel_write;
  logic [MASK_W-1:0]   sel_wmask;
  logic [ADDR_W-1:0]   sel_address;
  logic [DATA_W-1:0]   sel_wdata;

  assign others_pending = |src_request[NUM_SOURCES-1:1];
  assign any_request    = |src_request;
  assign prio_wins      = src_request[0] &&
                          (PRIO_MAX_BURST == 0 || !others_pending || prio_count < PC_MAX);

  // Round-robin scan over 1..NUM_SOURCES-1 starting just after rr_ptr;
  // source 0 never takes part in this search.
  always_comb begin
    rr_found  = 1'b0;
    rr_winner = '0;
    rr_cand   = '0;
    for (int unsigned k = 1; k < NUM_SOURCES; k++) begin
      rr_cand = GS_W'(((32'(rr_ptr) + k - 1) % (NUM_SOURCES - 1)) + 1);
      if (!rr_found && src_request[rr_cand]) begin
        rr_found  = 1'b1;
        rr_winner = rr_cand;
      end
    end
  end

  always_comb begin
    winner      = prio_wins ? '0 : rr_winner;
    sel_write   = 1'b0;
    sel_wmask   = '0;
    sel_address = '0;
    sel_wdata   = '0;
    for (int unsigned i = 0; i < NUM_SOURCES; i++) begin
      if (GS_W'(i) == winner) begin
        sel_write   = src_write[i];
        sel_wmask   = src_wmask[i*MASK_W +: MASK_W];
        sel_address = src_address[i*ADDR_W +: ADDR_W];
        sel_wdata   = src_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    src_ack    = '0;
    case (state)
      IDLE: begin
        if (any_request) state_next = WAIT;
      end
      WAIT: begin
        if (mem_ack) begin
          state_next            = IDLE;
          src_ack[grant_source] = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grant_source <= '0;
      prio_count   <= '0;
      rr_ptr       <= RR_RESET;
      mem_write    <= 1'b0;
      mem_wmask    <= '0;
      mem_address  <= '0;
      mem_wdata    <= '0;
    end else if (state == IDLE && any_request) begin
      grant_source <= winner;
      mem_write    <= sel_write;
      mem_wmask    <= sel_wmask;
      mem_address  <= sel_address;
      mem_wdata    <= sel_wdata;
      if (prio_wins) begin
        if (!others_pending)          prio_count <= '0;
        else if (prio_count != PC_MAX) prio_count <= prio_count + 1'b1;
      end else begin
        prio_count <= '0;
        rr_ptr     <= winner;
      end
    end
  end

  // The request and busy flags are exactly "a transaction is in WAIT".
  assign mem_request = (state == WAIT);
  assign busy        = (state == WAIT);
  assign src_rdata   = mem_rdata;

endmodule

// File: doc/mem_sdram_scheduler.md
Name: mem_sdram_scheduler

Overview:
Shares the single SDRAM mem_bus target among NUM_SOURCES requesters: N64, CFG, USB DMA and SD DMA. Source 0 (N64) is the priority source and has a bounded burst allowance. The remaining sources are served round-robin so that a DMA engine cannot starve the others. The block sits between the per-source mem_bus controllers and the SDRAM controller and replaces fixed-priority selection on that path.

Parameters:
NUM_SOURCES, 4, number of requesters; index 0 is the priority source; legal range 2..8
ADDR_W, 27, address width
DATA_W, 16, data width
MASK_W, DATA_W/8, byte write-mask width
PRIO_MAX_BURST, 4, max consecutive source-0 grants while any other source is pending; 0 = strict priority (unlimited)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
src_request  in  NUM_SOURCES  per-source request; held until that source's ack
src_write  in  NUM_SOURCES  per-source write flag
src_wmask  in  NUM_SOURCES*MASK_W  packed write masks; source i at [i*MASK_W +: MASK_W]
src_address  in  NUM_SOURCES*ADDR_W  packed addresses
src_wdata  in  NUM_SOURCES*DATA_W  packed write data
src_ack  out  NUM_SOURCES  one-hot ack to the granted source
src_rdata  out  DATA_W  read data, broadcast to all sources
mem_request  out  1  request to SDRAM controller
mem_write  out  1  latched write flag
mem_wmask  out  MASK_W  latched mask
mem_address  out  ADDR_W  latched address
mem_wdata  out  DATA_W  latched write data
mem_ack  in  1  SDRAM completion strobe, one cycle
mem_rdata  in  DATA_W  SDRAM read data, valid with mem_ack
busy  out  1  a transaction is outstanding
grant_source  out  $clog2(NUM_SOURCES)  index of the current or last granted source

Behaviour:
- Reset (synchronous, any state, including mid-transaction):
  - state IDLE; mem_request=0; busy=0; src_ack=0.
  - grant_source=0; prio_count=0.
  - rr_ptr=NUM_SOURCES-1, so the first round-robin search starts at source 1.
  - mem_write/wmask/address/wdata reset to 0.
- States:
  - IDLE: if no src_request bit is set, stay in IDLE. Otherwise choose a winner, register the winner's write/wmask/address/wdata onto mem_*, set mem_request=1, busy=1, grant_source=winner, and go to WAIT. Latency from request sampled in IDLE to mem_request high is 1 cycle.
  - WAIT: hold mem_request and all mem_* fields stable until mem_ack. In the mem_ack cycle, src_ack[grant_source]=mem_ack (combinational, same cycle). At the clock edge, mem_request<=0, busy<=0, and the state returns to IDLE.
- Requests are sampled only in IDLE. Request changes during WAIT are ignored.
- Back-to-back throughput: one grant per (mem_ack cycle + 1 IDLE cycle).
- Winner selection:
  - others_pending = any src_request[1..N-1].
  - Source 0 wins if src_request[0] and (PRIO_MAX_BURST==0, or !others_pending, or prio_count<PRIO_MAX_BURST).
  - Otherwise, the first pending source found scanning rr_ptr+1, rr_ptr+2, ..., wrapping within 1..N-1. Source 0 is never part of this scan.
- prio_count:
  - Increments on each source-0 grant while others_pending, saturating at PRIO_MAX_BURST.
  - Clears to 0 on any non-priority grant, or on a source-0 grant with !others_pending.
- rr_ptr updates to the winner index only on a non-priority grant.
- src_ack is 0 for all sources outside the mem_ack cycle in WAIT.
- A mem_ack arriving in IDLE is ignored: no src_ack, no state change.
- src_rdata = mem_rdata combinationally. It is meaningful only to the acked source during its ack cycle.
- Sources must drop src_request on the clock edge where their ack is seen. A request still high in the following IDLE cycle is treated as a new transaction.

Test Plan:
- Single source 2 read at address 0x0000100: mem_request rises 1 cycle later with mem_address=0x0000100, mem_write=0. mem_ack asserted with mem_rdata=0xBEEF -> src_ack=4'b0100 in the same cycle, src_rdata=0xBEEF, busy=0 next cycle.
- Sources 1, 2 and 3 request continuously, each re-requesting right after its ack -> grant order 1,2,3,1,2,3. No source waits more than 2 grants.
- PRIO_MAX_BURST=4, source 0 and source 3 request continuously -> grant order 0,0,0,0,3,0,0,0,0,3.
- PRIO_MAX_BURST=0, same stimulus as above -> source 0 granted every time; source 3 never granted while source 0 is pending.
- Reset asserted during WAIT with mem_request=1 -> next cycle mem_request=0, src_ack=0, busy=0. A later request from source 1 is granted first (rr_ptr restored to 3).
- Source 1 write with wmask=2'b10, wdata=0x1234, and src_address changed during WAIT -> mem_address/mem_wdata/mem_wmask stay at the values latched at grant until mem_ack. A stray mem_ack in IDLE produces no src_ack.
